pcileech_com_tx_arb: RTL and testbench
======================================

# pcileech_com_tx_arb

Packet-aware weighted round-robin arbiter that shares the single 256-bit transmit path toward the FT601 communication core between several upstream producers: PCIe TLP, config-space readback, loopback and status. It sits between those producers and the com transmit input inside the FIFO control domain, on the main 100 MHz `clk`. A grant is held for the whole packet, so output words from different sources never interleave. A per-source weight sets how many packets a source may send back-to-back before the grant rotates.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_W`, default 256: word width; matches the com transmit input.
- `WEIGHT_W`, default 4: width of each per-source weight field.
- `MAX_BEATS`, default 64: watchdog limit, in beats, for a single packet.
- `clk`, in, 1: system clock; the only clock in the block.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `req_valid`, in, NUM_REQ: per-source word valid.
- `req_data`, in, NUM_REQ×DATA_W: per-source word, packed with source 0 in the LSBs.
- `req_last`, in, NUM_REQ: per-source last-word-of-packet flag.
- `req_ready`, out, NUM_REQ: per-source accept; one-hot or zero.
- `cfg_weight`, in, NUM_REQ×WEIGHT_W: packets per turn for each source; a value of 0 is treated as 1.
- `out_data`, out, DATA_W: registered output word.
- `out_valid`, out, 1: output word valid.
- `out_last`, out, 1: output last-word flag.
- `out_src`, out, $clog2(NUM_REQ): index of the source that produced the current output word.
- `out_ready`, in, 1: downstream accept; driven by the com transmit-ready signal.
- `err_watchdog`, out, 1: sticky flag; set on a forced release, cleared only by reset.

## Operation
- State machine with two states:
  - IDLE: no grant is held.
  - BUSY: one source is granted and its packet is in flight.
- IDLE → BUSY:
  - Taken when any `req_valid` bit is set.
  - The winner is the first valid source scanning upward, with wrap-around, starting from `rr_ptr`.
  - On this transition, `credit` is loaded with the winner's effective weight.
- Transfer rule in BUSY:
  - `req_ready[g] = (~out_valid | out_ready)`, where g is the granted source.
  - A beat is accepted when `req_valid[g] & req_ready[g]`.
  - An accepted beat is copied into the output register together with `req_last[g]` and the source index g.
  - `beat_cnt` increments on each accepted beat and clears after each accepted last beat.
- On an accepted last beat, `credit` decrements. Then:
  - If `credit` is still nonzero and `req_valid[g]` is high in the next cycle, the arbiter stays in BUSY with the same grant.
  - Otherwise it returns to IDLE with `rr_ptr = g+1` (mod NUM_REQ).
- Watchdog:
  - Triggers when `beat_cnt` reaches MAX_BEATS without a last beat.
  - The accepted beat that hits the limit is emitted with `out_last` forced to 1.
  - `err_watchdog` sets, and the FSM returns to IDLE with the pointer advanced.
  - Any remainder of that source's packet is arbitrated later as a new packet.
- `cfg_weight` is sampled only when a grant is issued; changes mid-turn have no effect on the current turn.
- If `req_valid[g]` drops mid-packet, the arbiter stays in BUSY and waits. There is no timeout other than the beat watchdog.

## Timing
- Reset values: `req_ready=0`, `out_valid=0`, `out_last=0`, `out_src=0`, `out_data=0`, `err_watchdog=0`, `rr_ptr=0`, state IDLE, `beat_cnt=0`, `credit=0`.
- Grant latency:
  - The arbitration decision takes 1 cycle. `req_valid` sampled in IDLE at cycle N gives `req_ready` high at N+1.
  - The first word appears on `out_valid` at N+2.
- Data latency: 1 cycle from acceptance to `out_*`.
- Throughput: 1 word per clock while `out_ready=1`.
- `out_*` holds stable while `out_valid & ~out_ready`.
- Rotation bubble: exactly one idle cycle on the request side between a packet from source A and a packet from source B. The same source continuing on credit has no bubble.
- Simultaneous requests: the round-robin pointer decides. After reset, source 0 has priority.
- A `rst_n` low sample during a packet drops the packet mid-stream. All state returns to reset values on the following edge; no partial flush is performed.

## Structure
- Shared package `pcileech_arb_pkg`:
  - State enum (IDLE, BUSY).
  - Function `rr_pick(valid, ptr)` returning the winner index and a found bit.
  - Constant for the effective-weight computation (0 → 1).
- One sub-module, `pcileech_rr_pick`: combinational rotate / priority-encode / un-rotate. It is reused by the cfg/tlp muxes.
- The output register and FSM live in the top of the block.

## Test plan
- Reset and single source: `rst_n=0` for 3 cycles, then source 1 sends a 4-beat packet with `out_ready=1` → `req_ready` rises 1 cycle after valid; 4 words appear on `out_*` with `out_src=1`; `out_last` is set only on beat 4.
- Fair rotation: all four sources always valid, 1-beat packets, weights all 1 → `out_src` sequence is 0,1,2,3,0,… with one bubble between packets.
- Weighting: weights {3,1,0,1}, 2-beat packets, all sources valid → per round, packet order is 0,0,0,1,2,3; the zero weight behaves as 1.
- Backpressure: 8-beat packet from source 2 with `out_ready` toggling 1,0,0,1,… → no word is lost or duplicated; `out_data` holds stable during stalls; data order is preserved.
- Watchdog: MAX_BEATS=4, source 0 streams 6 beats without last → beat 4 is emitted with `out_last=1`; `err_watchdog` goes to 1 and stays; source 1, if valid, is granted next; the remaining 2 beats form a later packet.
- Mid-packet reset: assert `rst_n=0` at beat 3 of a 6-beat packet → on the next edge all outputs return to reset values and `rr_ptr=0`; after release, a new request from source 3 is granted normally.

Source files
------------

// File: rtl/pcileech_arb_pkg.sv
// rtl/pcileech_arb_pkg.sv - shared types and helpers for the com transmit arbiter
//
// Purpose : arbiter state enum, round-robin pick helper and the floor used
//           to turn a zero weight into a one-packet turn.
// Contents: arb_state_e, pick_t, EFF_WEIGHT_MIN, MAX_REQ, rr_pick().
package pcileech_arb_pkg;

   localparam int MAX_REQ        = 8;
   localparam int EFF_WEIGHT_MIN = 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // idx sits in the LSBs so a truncating cast yields the winner index.
   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // Rotate the request vector so ptr lands at bit 0, take the lowest set
   // bit, then rotate the index back. Only the low n bits of valid count.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                     input logic [2:0] ptr,
                                     input int n);
      logic [MAX_REQ-1:0] rot;
      pick_t              r;
      r   = '0;
      rot = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (i < n) rot[i] = valid[3'((int'(ptr) + i) % n)];
      end
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            r.found = 1'b1;
            r.idx   = 3'((int'(ptr) + i) % n);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pcileech_rr_pick.sv
// rtl/pcileech_rr_pick.sv - combinational round-robin winner select
//
// Purpose : first set bit of valid scanning upward from ptr with wrap-around.
// Ports   : valid [N]      request vector
//           ptr   [log2 N] highest-priority index this round
//           idx   [log2 N] winning index (meaningful only when found)
//           found          at least one request present
module pcileech_rr_pick
   import pcileech_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);

   localparam int IDX_W = $clog2(N);

   always_comb begin
      idx   = IDX_W'(rr_pick(8'(valid), 3'(ptr), N));
      found = |valid;
   end

endmodule

// File: rtl/pcileech_com_tx_arb.sv
// rtl/pcileech_com_tx_arb.sv - packet-aware weighted round-robin tx arbiter
//
// Purpose : shares the com transmit path between NUM_REQ producers, holding
//           each grant for whole packets and up to cfg_weight packets a turn.
// Ports   : clk, rst_n                   clock, sync active-low reset
//           req_valid/req_data/req_last   per-source stream in (source 0 LSBs)
//           req_ready                     per-source accept, one-hot or zero
//           cfg_weight                    packets per turn, 0 acts as 1
//           out_data/out_valid/out_last   registered stream out
//           out_src                       source of the current out word
//           out_ready                     downstream accept
//           err_watchdog                  sticky forced-release flag
module pcileech_com_tx_arb
   import pcileech_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 256,
   parameter int WEIGHT_W  = 4,
   parameter int MAX_BEATS = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*WEIGHT_W-1:0]  cfg_weight,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   output logic                         out_last,
   output logic [$clog2(NUM_REQ)-1:0]   out_src,
   input  logic                         out_ready,
   output logic                         err_watchdog
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   arb_state_e          state;
   logic [IDX_W-1:0]    grant;
   logic [IDX_W-1:0]    rr_ptr;
   logic [WEIGHT_W-1:0] credit;
   logic [CNT_W-1:0]    beat_cnt;
   // Set between packets of one turn: the source must still be valid on the
   // following cycle to keep the grant, otherwise the turn ends.
   logic                cont;

   logic [IDX_W-1:0]    win_idx;
   logic                win_found;
   logic [WEIGHT_W-1:0] win_weight;
   logic [WEIGHT_W-1:0] credit_dec;
   logic [IDX_W-1:0]    next_ptr;
   logic                cur_valid;
   logic                cur_last;
   logic                busy_ready;
   logic                accept;
   logic                wd_hit;

   pcileech_rr_pick #(.N(NUM_REQ)) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .idx   (win_idx),
      .found (win_found)
   );

   always_comb begin
      win_weight = cfg_weight[win_idx*WEIGHT_W +: WEIGHT_W];
      if (win_weight == '0) win_weight = WEIGHT_W'(EFF_WEIGHT_MIN);
      cur_valid  = req_valid[grant];
      cur_last   = req_last[grant];
      busy_ready = (state == BUSY) && (!out_valid || out_ready);
      accept     = busy_ready && cur_valid;
      // A real last on the limit beat is a normal end, not a watchdog event.
      wd_hit     = accept && !cur_last && (beat_cnt == CNT_W'(MAX_BEATS - 1));
      credit_dec = credit - 1'b1;
      next_ptr   = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      req_ready  = '0;
      if (busy_ready) req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         rr_ptr       <= '0;
         credit       <= '0;
         beat_cnt     <= '0;
         cont         <= 1'b0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_src      <= '0;
         err_watchdog <= 1'b0;
      end else begin
         if (accept) begin
            out_data  <= req_data[grant*DATA_W +: DATA_W];
            out_valid <= 1'b1;
            out_last  <= cur_last || wd_hit;
            out_src   <= grant;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (win_found) begin
                  state    <= BUSY;
                  grant    <= win_idx;
                  credit   <= win_weight;
                  beat_cnt <= '0;
                  cont     <= 1'b0;
               end
            end
            BUSY: begin
               if (accept) begin
                  cont <= 1'b0;
                  if (cur_last) begin
                     beat_cnt <= '0;
                     credit   <= credit_dec;
                     if (credit_dec != '0) begin
                        cont <= 1'b1;
                     end else begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                     end
                  end else if (wd_hit) begin
                     beat_cnt     <= '0;
                     err_watchdog <= 1'b1;
                     state        <= IDLE;
                     rr_ptr       <= next_ptr;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end else if (cont && !cur_valid) begin
                  cont   <= 1'b0;
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcileech_com_tx_arb.sv
// tb/tb_pcileech_com_tx_arb.sv - self-checking bench for pcileech_com_tx_arb
module tb_pcileech_com_tx_arb;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int WW = 4;
   localparam int MB = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_last;
   logic [NR-1:0]    req_ready;
   logic [NR*WW-1:0] cfg_weight;
   logic [DW-1:0]    out_data;
   logic             out_valid;
   logic             out_last;
   logic [1:0]       out_src;
   logic             out_ready;
   logic             err_watchdog;

   always #5 clk = ~clk;

   pcileech_com_tx_arb #(.NUM_REQ(NR), .DATA_W(DW), .WEIGHT_W(WW), .MAX_BEATS(MB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .cfg_weight   (cfg_weight),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_last     (out_last),
      .out_src      (out_src),
      .out_ready    (out_ready),
      .err_watchdog (err_watchdog)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t       src_q [NR][$];   // words each producer still has to offer
   beat_t       exp_q [NR][$];   // words accepted, awaiting output
   int          run_cnt [NR];    // words emitted since that source's last
   int          acc_cyc[$];
   int          acc_src[$];
   int          out_cyc[$];
   int          pkt_log[$];
   int          cyc;
   int          or_mode;
   bit          rand_valid;
   int          err_cyc;
   bit          prev_stall;
   logic [DW-1:0] hold_data;
   logic        hold_last;
   logic [1:0]  hold_src;
   bit          in_pkt;
   int          pkt_src;
   int          tests = 0;
   int          fails = 0;

   task automatic clear_model();
      for (int s = 0; s < NR; s++) begin
         src_q[s].delete();
         exp_q[s].delete();
         run_cnt[s] = 0;
      end
      acc_cyc.delete(); acc_src.delete(); out_cyc.delete(); pkt_log.delete();
      prev_stall = 0; in_pkt = 0; err_cyc = -1; cyc = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      or_mode = 0; rand_valid = 0;
   endtask

   // One clock: drive at negedge, observe 1 ns later, commit handshakes at posedge.
   task automatic cycle();
      int    hs;
      int    s;
      bit    v;
      beat_t e;
      bit    exp_last;
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
         v = (src_q[k].size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
         req_valid[k] = v;
         req_data[k*DW +: DW] = v ? src_q[k][0].data : DW'($urandom);
         req_last[k] = v ? src_q[k][0].last : 1'b0;
      end
      case (or_mode)
         0: out_ready = 1'b1;
         1: out_ready = (cyc % 3 == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      tests++;
      if ((req_ready & (req_ready - 1'b1)) != '0) begin
         fails++; $display("FAIL ready_onehot: got %b required one-hot or zero", req_ready);
      end
      if (prev_stall) begin
         tests++;
         if (out_valid !== 1'b1 || out_data !== hold_data || out_last !== hold_last || out_src !== hold_src) begin
            fails++; $display("FAIL stall_hold: got v=%b d=%h l=%b s=%0d required v=1 d=%h l=%b s=%0d",
                              out_valid, out_data, out_last, out_src, hold_data, hold_last, hold_src);
         end
      end
      if (err_watchdog === 1'b1 && err_cyc < 0) err_cyc = cyc;
      if (out_valid && out_ready) begin
         s = int'(out_src);
         tests++;
         if (in_pkt && s != pkt_src) begin
            fails++; $display("FAIL interleave: got src %0d required src %0d", s, pkt_src);
         end
         tests++;
         if (exp_q[s].size() == 0) begin
            fails++; $display("FAIL unexpected_word: got src %0d data %h required no word", s, out_data);
         end else begin
            e = exp_q[s].pop_front();
            exp_last = e.last || (run_cnt[s] == MB - 1);
            run_cnt[s] = exp_last ? 0 : run_cnt[s] + 1;
            if (out_data !== e.data || out_last !== exp_last) begin
               fails++; $display("FAIL out_word: got src %0d data %h last %b required data %h last %b",
                                 s, out_data, out_last, e.data, exp_last);
            end
         end
         out_cyc.push_back(cyc);
         if (out_last) begin pkt_log.push_back(s); in_pkt = 0; end
         else begin in_pkt = 1; pkt_src = s; end
      end
      prev_stall = out_valid && !out_ready;
      hold_data = out_data; hold_last = out_last; hold_src = out_src;
      hs = -1;
      for (int k = 0; k < NR; k++) if (req_valid[k] && req_ready[k]) hs = k;
      if (hs >= 0) begin acc_cyc.push_back(cyc); acc_src.push_back(hs); end
      @(posedge clk);
      if (hs >= 0) exp_q[hs].push_back(src_q[hs].pop_front());
      cyc++;
   endtask

   function automatic bit pending();
      for (int s = 0; s < NR; s++) if (src_q[s].size() > 0 || exp_q[s].size() > 0) return 1;
      return 0;
   endfunction

   task automatic run_until_drained(input int limit);
      int n;
      n = 0;
      while (pending() && n < limit) begin cycle(); n++; end
      tests++;
      if (pending()) begin fails++; $display("FAIL drain_timeout: got %0d cycles required all words out", n); end
   endtask

   task automatic push_pkt(input int s, input int len);
      for (int b = 0; b < len; b++) src_q[s].push_back('{data: DW'($urandom), last: (b == len - 1)});
   endtask

   task automatic check_order(input string name, input int exp_order[$]);
      tests++;
      if (pkt_log.size() != exp_order.size()) begin
         fails++; $display("FAIL %s_count: got %0d packets required %0d", name, pkt_log.size(), exp_order.size());
      end else begin
         for (int i = 0; i < exp_order.size(); i++) begin
            tests++;
            if (pkt_log[i] != exp_order[i]) begin
               fails++; $display("FAIL %s_order[%0d]: got src %0d required src %0d", name, i, pkt_log[i], exp_order[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      cfg_weight = '0;
      apply_reset();
      #1;
      tests += 6;
      if (req_ready !== '0)       begin fails++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
      if (out_valid !== 1'b0)     begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      if (out_last !== 1'b0)      begin fails++; $display("FAIL rst_out_last: got %b required 0", out_last); end
      if (out_src !== '0)         begin fails++; $display("FAIL rst_out_src: got %0d required 0", out_src); end
      if (out_data !== '0)        begin fails++; $display("FAIL rst_out_data: got %h required 0", out_data); end
      if (err_watchdog !== 1'b0)  begin fails++; $display("FAIL rst_err: got %b required 0", err_watchdog); end
   endtask

   task automatic test_single_source();
      int q[$];
      apply_reset();
      cfg_weight = {NR{4'd1}};
      push_pkt(1, 4);
      run_until_drained(100);
      tests += 3;
      if (acc_cyc.size() != 4) begin fails++; $display("FAIL single_beats: got %0d required 4", acc_cyc.size()); end
      else if (acc_cyc[0] != 1 || acc_cyc[3] != 4) begin
         fails++; $display("FAIL single_grant_latency: got first %0d last %0d required 1 and 4", acc_cyc[0], acc_cyc[3]);
      end
      if (out_cyc.size() == 0 || out_cyc[0] != 2) begin
         fails++; $display("FAIL single_out_latency: got %0d required 2", out_cyc.size() ? out_cyc[0] : -1);
      end
      q = '{1};
      check_order("single", q);
   endtask

   task automatic test_fair_rotation();
      int q[$];
      apply_reset();
      cfg_weight = {NR{4'd1}};
      for (int r = 0; r < 3; r++) for (int s = 0; s < NR; s++) begin push_pkt(s, 1); q.push_back(s); end
      run_until_drained(200);
      check_order("fair", q);
      for (int k = 1; k < acc_cyc.size(); k++) begin
         tests++;
         if (acc_cyc[k] - acc_cyc[k-1] != 2) begin
            fails++; $display("FAIL fair_bubble[%0d]: got gap %0d required 2", k, acc_cyc[k] - acc_cyc[k-1]);
         end
      end
   endtask

   task automatic test_weighting();
      int w[NR];
      int q[$];
      bit turn_start[$];
      int gap;
      apply_reset();
      w = '{3, 1, 0, 1};
      for (int s = 0; s < NR; s++) cfg_weight[s*WW +: WW] = WW'(w[s]);
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < NR; s++)
            for (int p = 0; p < ((w[s] == 0) ? 1 : w[s]); p++) begin
               q.push_back(s); turn_start.push_back(p == 0); push_pkt(s, 2);
            end
      run_until_drained(300);
      check_order("weight", q);
      tests++;
      if (acc_cyc.size() != 2 * q.size()) begin
         fails++; $display("FAIL weight_beats: got %0d required %0d", acc_cyc.size(), 2 * q.size());
      end else begin
         for (int k = 1; k < acc_cyc.size(); k++) begin
            gap = (k % 2 == 1) ? 1 : (turn_start[k/2] ? 2 : 1);
            tests++;
            if (acc_cyc[k] - acc_cyc[k-1] != gap) begin
               fails++; $display("FAIL weight_gap[%0d]: got %0d required %0d", k, acc_cyc[k] - acc_cyc[k-1], gap);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int q[$];
      apply_reset();
      cfg_weight = {NR{4'd1}};
      or_mode = 1;
      push_pkt(2, 8);
      run_until_drained(200);
      tests++;
      if (out_cyc.size() != 8) begin fails++; $display("FAIL bp_words: got %0d required 8", out_cyc.size()); end
      q = '{2};
      check_order("bp", q);
   endtask

   task automatic test_watchdog();
      int q[$];
      apply_reset();
      cfg_weight = {NR{4'd1}};
      push_pkt(0, 10);
      push_pkt(1, 1);
      run_until_drained(200);
      q = '{0, 1, 0};
      check_order("wd", q);
      tests += 2;
      if (err_watchdog !== 1'b1) begin fails++; $display("FAIL wd_sticky: got %b required 1", err_watchdog); end
      if (out_cyc.size() < 8 || err_cyc != out_cyc[7]) begin
         fails++; $display("FAIL wd_set_cycle: got %0d required %0d", err_cyc, out_cyc.size() >= 8 ? out_cyc[7] : -1);
      end
   endtask

   task automatic test_midpacket_reset();
      int q[$];
      int n;
      apply_reset();
      cfg_weight = {NR{4'd1}};
      push_pkt(2, 1);
      run_until_drained(50);
      push_pkt(2, 6);
      n = 0;
      while (acc_cyc.size() < 4 && n < 100) begin cycle(); n++; end
      tests++;
      if (acc_cyc.size() != 4) begin fails++; $display("FAIL mr_reach_beat3: got %0d accepts required 4", acc_cyc.size()); end
      for (int s = 0; s < NR; s++) src_q[s].delete();
      rst_n = 1'b0;
      cycle();
      @(negedge clk);
      #1;
      tests += 5;
      if (req_ready !== '0)   begin fails++; $display("FAIL mr_req_ready: got %b required 0", req_ready); end
      if (out_valid !== 1'b0) begin fails++; $display("FAIL mr_out_valid: got %b required 0", out_valid); end
      if (out_last !== 1'b0)  begin fails++; $display("FAIL mr_out_last: got %b required 0", out_last); end
      if (out_src !== '0)     begin fails++; $display("FAIL mr_out_src: got %0d required 0", out_src); end
      if (out_data !== '0)    begin fails++; $display("FAIL mr_out_data: got %h required 0", out_data); end
      rst_n = 1'b1;
      clear_model();
      push_pkt(3, 1);
      push_pkt(1, 1);
      run_until_drained(50);
      q = '{1, 3};
      check_order("mr", q);
   endtask

   task automatic test_random();
      int total;
      apply_reset();
      for (int s = 0; s < NR; s++) cfg_weight[s*WW +: WW] = WW'($urandom_range(0, 3));
      rand_valid = 1;
      or_mode = 2;
      total = 0;
      for (int p = 0; p < 5; p++)
         for (int s = 0; s < NR; s++) begin
            int len;
            len = $urandom_range(1, 6);
            push_pkt(s, len);
            total += len;
         end
      run_until_drained(5000);
      tests++;
      if (out_cyc.size() != total) begin fails++; $display("FAIL rand_words: got %0d required %0d", out_cyc.size(), total); end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1; cfg_weight = '0;
      test_reset();
      test_single_source();
      test_fair_rotation();
      test_weighting();
      test_backpressure();
      test_watchdog();
      test_midpacket_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
